// File: rtl/memory_stage.sv
// Purpose : memory stage of the 5-stage core; issues data-memory accesses and fills the MEM/WB register.
// Latency : 1 cycle for non-memory instructions, N+1 cycles for a memory op whose mem_done arrives N cycles after the request.
// Backpressure: stall is raised combinationally from the request cycle until the mem_done cycle; upstream holds its inputs meanwhile.
//
// Ports:
//   clk, rst                        core clock, asynchronous active-high reset
//   in_valid, ALU_Out, RTData_ff,   execute-register outputs (ALU_Out doubles as the memory address)
//   MemWrt_2ff, MemRead_2ff,
//   nHaltSig_2ff, PC_2ff
//   stall                           upstream hold request (combinational)
//   mem_req/mem_wr/mem_addr/        single-cycle request strobe and its payload to data memory
//   mem_wdata
//   mem_rdata, mem_done             data-memory response (rdata valid with done)
//   wb_*                            MEM/WB pipeline register
//   halted                          sticky: a HALT has been retired into writeback
//
// Build option: define MEM_ALIGN_CHECK_EN to trap odd-address memory ops with wb_err instead of
// issuing them to memory. Without it every address passes through and wb_err is tied low.

module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] ALU_Out,
    input  logic [15:0] RTData_ff,
    input  logic        MemWrt_2ff,
    input  logic        MemRead_2ff,
    input  logic        nHaltSig_2ff,
    input  logic [15:0] PC_2ff,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        wb_valid,
    output logic        wb_nHalt,
    output logic        wb_err,
    output logic [15:0] wb_MemOut,
    output logic [15:0] wb_ALU_Out,
    output logic [15:0] wb_PC,
    output logic        halted
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;

    logic is_mem_op;
    logic misaligned;
    logic issue;

    // Once halted, everything upstream is a bubble, including memory ops.
    assign is_mem_op = in_valid & nHaltSig_2ff & (MemRead_2ff | MemWrt_2ff) & ~halted;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ALU_Out[0];
`else
    assign misaligned = 1'b0;
`endif

    // Requests only leave from IDLE, so the strobe can never repeat on the next cycle
    // (the following cycle is always spent in WAIT). Gated by rst so the bus is quiet in reset.
    assign issue     = ~rst & (state == S_IDLE) & is_mem_op & ~misaligned;

    assign mem_req   = issue;
    assign mem_wr    = issue & MemWrt_2ff;           // write wins if both read and write are set
    assign mem_addr  = issue ? ALU_Out   : 16'h0000;
    assign mem_wdata = issue ? RTData_ff : 16'h0000;

    // stall drops in the mem_done cycle so upstream advances on the same edge that captures the result.
    assign stall     = ~rst & (issue | ((state == S_WAIT) & ~mem_done));

`ifndef MEM_ALIGN_CHECK_EN
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            halted     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_nHalt   <= 1'b0;
            wb_MemOut  <= 16'h0000;
            wb_ALU_Out <= 16'h0000;
            wb_PC      <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
            wb_err     <= 1'b0;
`endif
        end else begin
            // Default every cycle to a bubble; the branches below override when something retires.
            wb_valid   <= 1'b0;
            wb_nHalt   <= 1'b0;
            wb_MemOut  <= 16'h0000;
            wb_ALU_Out <= 16'h0000;
            wb_PC      <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
            wb_err     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (is_mem_op && !misaligned) begin
                        state <= S_WAIT;
                    end else if (in_valid && !halted) begin
                        // Non-memory instruction, HALT, or a trapped misaligned memory op.
                        wb_valid   <= 1'b1;
                        wb_nHalt   <= nHaltSig_2ff;
                        wb_ALU_Out <= ALU_Out;
                        wb_PC      <= PC_2ff;
                        halted     <= ~nHaltSig_2ff;
`ifdef MEM_ALIGN_CHECK_EN
                        wb_err     <= is_mem_op & misaligned;
`endif
                    end
                end
                S_WAIT: begin
                    // Inputs are still the original instruction: upstream held them while stalled.
                    if (mem_done) begin
                        state      <= S_IDLE;
                        wb_valid   <= 1'b1;
                        wb_nHalt   <= nHaltSig_2ff;
                        wb_ALU_Out <= ALU_Out;
                        wb_PC      <= PC_2ff;
                        wb_MemOut  <= (MemRead_2ff && !MemWrt_2ff) ? mem_rdata : 16'h0000;
                    end
                end
            endcase
        end
    end

endmodule
